// File: rtl/mem_hs_port_if.sv
// Request/response handshake bundle between a memory client and mem_hs_port.
// The master drives requests and accepts responses; the slave is the memory port.
interface mem_hs_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_signed, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_signed, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_hs_port.sv
// Handshaked big-endian byte-addressed data memory with one outstanding request,
// programmable wait states and error reporting for bad size, alignment and range.
module mem_hs_port #(
  parameter int unsigned SIZE    = 'h100000,
  parameter logic [31:0] OFFSET  = 32'h80020000,
  parameter int unsigned LATENCY = 2
) (
  input logic         clk,
  input logic         rst,
  mem_hs_port_if.slave bus
);

  localparam int AW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_write;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [1:0]  l_size;
  logic        l_signed;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [7:0]  mem [SIZE];

  logic        c_write;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_size;
  logic        c_signed;
  logic        c_err;
  logic        commit;
  logic [2:0]  nbytes;
  logic [32:0] idx33;
  logic [32:0] end33;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rd_data;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // With zero wait states the commit happens on the accept edge, straight from the bus.
  assign commit = (state == IDLE && bus.req_valid && LATENCY == 0) ||
                  (state == WAIT && cnt == 4'd0);

  always_comb begin
    if (state == IDLE) begin
      c_write  = bus.req_write;
      c_addr   = bus.req_addr;
      c_wdata  = bus.req_wdata;
      c_size   = bus.req_size;
      c_signed = bus.req_signed;
    end else begin
      c_write  = l_write;
      c_addr   = l_addr;
      c_wdata  = l_wdata;
      c_size   = l_size;
      c_signed = l_signed;
    end
  end

  // 33-bit arithmetic keeps addresses near 2^32 from wrapping into range.
  always_comb begin
    case (c_size)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    idx33 = {1'b0, c_addr} - {1'b0, OFFSET};
    end33 = idx33 + {30'b0, nbytes};
    c_err = (c_size == 2'b11) ||
            (c_size == 2'b01 && c_addr[0]) ||
            (c_size == 2'b10 && c_addr[1:0] != 2'b00) ||
            (c_addr < OFFSET) ||
            (end33 > 33'(SIZE));
  end

  always_comb begin
    i0 = idx33[AW-1:0];
    i1 = i0 + AW'(1);
    i2 = i0 + AW'(2);
    i3 = i0 + AW'(3);
    b0 = mem[i0];
    b1 = mem[i1];
    b2 = mem[i2];
    b3 = mem[i3];
    case (c_size)
      2'b00:   rd_data = {{24{c_signed & b0[7]}}, b0};
      2'b01:   rd_data = {{16{c_signed & b0[7]}}, b0, b1};
      default: rd_data = {b0, b1, b2, b3};
    endcase
  end

  // Backing array: no reset, written only at the commit edge of a clean write.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err) begin
      case (c_size)
        2'b00: mem[i0] <= c_wdata[7:0];
        2'b01: begin
          mem[i0] <= c_wdata[15:8];
          mem[i1] <= c_wdata[7:0];
        end
        default: begin
          mem[i0] <= c_wdata[31:24];
          mem[i1] <= c_wdata[23:16];
          mem[i2] <= c_wdata[15:8];
          mem[i3] <= c_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      l_write      <= 1'b0;
      l_addr       <= 32'd0;
      l_wdata      <= 32'd0;
      l_size       <= 2'd0;
      l_signed     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_write  <= bus.req_write;
            l_addr   <= bus.req_addr;
            l_wdata  <= bus.req_wdata;
            l_size   <= bus.req_size;
            l_signed <= bus.req_signed;
            if (LATENCY == 0) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= (c_err || c_write) ? 32'd0 : rd_data;
              resp_err_q   <= c_err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY > 0 ? LATENCY - 1 : 0);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= (c_err || c_write) ? 32'd0 : rd_data;
            resp_err_q   <= c_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_hs_port.sv
// Directed bench for mem_hs_port: one LATENCY=2 instance and one LATENCY=0 instance
// sharing request stimulus, selected by 'sel'.
module tb_mem_hs_port;
  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic t_valid, t_write, t_signed, t_ready;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_size;
  logic        o_ready, o_rvalid, o_err;
  logic [31:0] o_rdata;
  int n_vec = 0;
  int n_fail = 0;

  mem_hs_port_if bus0();
  mem_hs_port_if bus1();

  assign bus0.req_valid  = t_valid & ~sel;
  assign bus1.req_valid  = t_valid & sel;
  assign bus0.req_write  = t_write;
  assign bus1.req_write  = t_write;
  assign bus0.req_addr   = t_addr;
  assign bus1.req_addr   = t_addr;
  assign bus0.req_wdata  = t_wdata;
  assign bus1.req_wdata  = t_wdata;
  assign bus0.req_size   = t_size;
  assign bus1.req_size   = t_size;
  assign bus0.req_signed = t_signed;
  assign bus1.req_signed = t_signed;
  assign bus0.resp_ready = t_ready;
  assign bus1.resp_ready = t_ready;

  assign o_ready  = sel ? bus1.req_ready  : bus0.req_ready;
  assign o_rvalid = sel ? bus1.resp_valid : bus0.resp_valid;
  assign o_rdata  = sel ? bus1.resp_rdata : bus0.resp_rdata;
  assign o_err    = sel ? bus1.resp_err   : bus0.resp_err;

  mem_hs_port #(.LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus0));
  mem_hs_port #(.LATENCY(0)) dut_l0 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  logic [31:0] exp_s [4] = '{32'hFFFFFFDE, 32'hFFFFFFAD, 32'hFFFFFFBE, 32'hFFFFFFEF};
  logic [31:0] exp_u [4] = '{32'h000000DE, 32'h000000AD, 32'h000000BE, 32'h000000EF};
  logic [1:0]  err_size [5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [31:0] err_addr [5] = '{32'h80020000, 32'h80020002, 32'h8001FFFC, 32'h8011FFFE, 32'hFFFFFFFC};

  // One full transaction with resp_ready=1; edges counts the accept edge as 1.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic sgn,
                      output logic [31:0] rdata, output logic err, output int edges,
                      output int stalls, output time t_acc);
    rdata = 32'd0; err = 1'b0; edges = 0; stalls = 0; t_acc = 0;
    t_write = wr; t_addr = addr; t_wdata = wdata; t_size = size; t_signed = sgn;
    t_valid = 1'b1; t_ready = 1'b1;
    while (!o_ready && stalls < 20) begin
      @(posedge clk); #1; stalls++;
    end
    if (!o_ready) begin
      n_vec++; n_fail++;
      $display("[TB] FAIL accept_timeout: req_ready stuck at %b, required 1", o_ready);
      t_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    t_valid = 1'b0; t_addr = ~addr; t_wdata = ~wdata; t_size = ~size; t_write = ~wr;
    edges = 1;
    while (!o_rvalid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    if (!o_rvalid) begin
      n_vec++; n_fail++;
      $display("[TB] FAIL resp_timeout: resp_valid stuck at %b, required 1", o_rvalid);
      return;
    end
    rdata = o_rdata; err = o_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sel = 1'b0; t_valid = 1'b0; t_write = 1'b0; t_addr = 32'd0; t_wdata = 32'd0;
    t_size = 2'd0; t_signed = 1'b0; t_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus0.req_ready); end
    n_vec++; if (bus0.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus0.resp_valid); end
    n_vec++; if (bus0.resp_rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", bus0.resp_rdata); end
    n_vec++; if (bus0.resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_err: got %b expected 0", bus0.resp_err); end
    n_vec++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_l0_req_ready: got %b expected 1", bus1.req_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int ed, st; time ta;
    xact(1'b1, 32'h80020000, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (ed != 3) begin n_fail++; $display("[TB] FAIL word_write_latency: got %0d expected 3", ed); end
    n_vec++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("[TB] FAIL word_write_resp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    xact(1'b0, 32'h80020000, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (ed != 3) begin n_fail++; $display("[TB] FAIL word_read_latency: got %0d expected 3", ed); end
    n_vec++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL word_read: got err=%b rdata=%h expected err=0 rdata=deadbeef", er, rd); end
  endtask

  task automatic test_bytes();
    logic [31:0] rd; logic er; int ed, st; time ta;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 32'h80020000 + 32'(i), 32'd0, 2'b00, 1'b1, rd, er, ed, st, ta);
      n_vec++; if (er !== 1'b0 || rd !== exp_s[i]) begin n_fail++; $display("[TB] FAIL byte_signed_%0d: got err=%b rdata=%h expected err=0 rdata=%h", i, er, rd, exp_s[i]); end
      xact(1'b0, 32'h80020000 + 32'(i), 32'd0, 2'b00, 1'b0, rd, er, ed, st, ta);
      n_vec++; if (er !== 1'b0 || rd !== exp_u[i]) begin n_fail++; $display("[TB] FAIL byte_unsigned_%0d: got err=%b rdata=%h expected err=0 rdata=%h", i, er, rd, exp_u[i]); end
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int ed, st; time ta;
    xact(1'b1, 32'h80020002, 32'h00001234, 2'b01, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL half_write_err: got %b expected 0", er); end
    xact(1'b0, 32'h80020000, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'hDEAD1234) begin n_fail++; $display("[TB] FAIL half_merge: got %h expected dead1234", rd); end
    xact(1'b0, 32'h80020001, 32'd0, 2'b01, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("[TB] FAIL half_misaligned: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    xact(1'b0, 32'h80020000, 32'd0, 2'b01, 1'b1, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("[TB] FAIL half_signed: got %h expected ffffdead", rd); end
    xact(1'b0, 32'h80020002, 32'd0, 2'b01, 1'b1, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'h00001234) begin n_fail++; $display("[TB] FAIL half_positive: got %h expected 00001234", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int ed, st; time ta;
    xact(1'b1, 32'h8002001C, 32'h00000000, 2'b10, 1'b0, rd, er, ed, st, ta);
    xact(1'b1, 32'h80020020, 32'h00000000, 2'b10, 1'b0, rd, er, ed, st, ta);
    for (int i = 0; i < 5; i++) begin
      xact(1'b1, err_addr[i], 32'h77777777, err_size[i], 1'b0, rd, er, ed, st, ta);
      n_vec++; if (er !== 1'b1 || rd !== 32'd0 || ed != 3) begin n_fail++; $display("[TB] FAIL err_case_%0d: got err=%b rdata=%h edges=%0d expected err=1 rdata=0 edges=3", i, er, rd, ed); end
    end
    xact(1'b0, 32'h80020000, 32'd0, 2'b11, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("[TB] FAIL err_reserved_read: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    xact(1'b0, 32'h80020000, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'hDEAD1234) begin n_fail++; $display("[TB] FAIL err_readback_0: got %h expected dead1234", rd); end
    xact(1'b0, 32'h8002001C, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL err_readback_1c: got %h expected 0", rd); end
    xact(1'b0, 32'h80020020, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL err_readback_20: got %h expected 0", rd); end
    xact(1'b1, 32'h8011FFFC, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL top_word_write_err: got %b expected 0", er); end
    xact(1'b0, 32'h8011FFFE, 32'd0, 2'b01, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (er !== 1'b0 || rd !== 32'h0000F00D) begin n_fail++; $display("[TB] FAIL top_half_read: got err=%b rdata=%h expected err=0 rdata=0000f00d", er, rd); end
    xact(1'b0, 32'h80120000, 32'd0, 2'b00, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL past_end_byte: got %b expected 1", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int ed, st, w; time ta;
    t_write = 1'b0; t_addr = 32'h80020000; t_size = 2'b10; t_signed = 1'b0;
    t_ready = 1'b0; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    w = 0;
    while (!o_rvalid && w < 20) begin @(posedge clk); #1; w++; end
    n_vec++; if (o_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_resp_valid: got %b expected 1", o_rvalid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (o_rvalid !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'hDEAD1234) begin n_fail++; $display("[TB] FAIL bp_hold_%0d: got valid=%b err=%b rdata=%h expected 1 0 dead1234", i, o_rvalid, o_err, o_rdata); end
      n_vec++; if (o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_ready_%0d: got %b expected 0", i, o_ready); end
      if (i == 1) begin
        t_valid = 1'b1; t_write = 1'b1; t_wdata = 32'h11111111;
      end else begin
        t_valid = 1'b0;
      end
    end
    t_ready = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h80020000, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (st != 0) begin n_fail++; $display("[TB] FAIL bp_next_accept: got %0d stall cycles expected 0", st); end
    n_vec++; if (rd !== 32'hDEAD1234) begin n_fail++; $display("[TB] FAIL bp_ignored_pulse: got %h expected dead1234", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int ed, st, w; time ta;
    t_write = 1'b1; t_addr = 32'h80020000; t_wdata = 32'h55555555; t_size = 2'b10;
    t_ready = 1'b1; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_vec++; if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0 || bus0.resp_rdata !== 32'd0 || bus0.resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0", bus0.req_ready, bus0.resp_valid, bus0.resp_rdata, bus0.resp_err); end
    #1 rst = 1'b0;
    xact(1'b0, 32'h80020000, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'hDEAD1234) begin n_fail++; $display("[TB] FAIL abort_old_data: got %h expected dead1234", rd); end
    // A write already in RESP has committed and must survive reset.
    t_write = 1'b1; t_addr = 32'h80020010; t_wdata = 32'h0BADCAFE; t_size = 2'b10;
    t_ready = 1'b0; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    w = 0;
    while (!o_rvalid && w < 20) begin @(posedge clk); #1; w++; end
    rst = 1'b1;
    #1;
    n_vec++; if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL resp_reset: got valid=%b ready=%b expected 0 1", bus0.resp_valid, bus0.req_ready); end
    #1 rst = 1'b0;
    xact(1'b0, 32'h80020010, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta);
    n_vec++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("[TB] FAIL committed_kept: got %h expected 0badcafe", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int ed, st; time ta0, ta1;
    sel = 1'b1;
    #1;
    xact(1'b1, 32'h80020000, 32'hA5A5A5A5, 2'b10, 1'b0, rd, er, ed, st, ta0);
    n_vec++; if (ed != 1) begin n_fail++; $display("[TB] FAIL l0_latency: got %0d expected 1", ed); end
    xact(1'b0, 32'h80020000, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta1);
    n_vec++; if (ta1 - ta0 != 20) begin n_fail++; $display("[TB] FAIL l0_period: got %0t expected 20", ta1 - ta0); end
    n_vec++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL l0_read: got %h expected a5a5a5a5", rd); end
    xact(1'b0, 32'h80020001, 32'd0, 2'b00, 1'b1, rd, er, ed, st, ta0);
    n_vec++; if (rd !== 32'hFFFFFFA5) begin n_fail++; $display("[TB] FAIL l0_byte_signed: got %h expected ffffffa5", rd); end
    xact(1'b0, 32'h80020002, 32'd0, 2'b10, 1'b0, rd, er, ed, st, ta0);
    n_vec++; if (er !== 1'b1 || ed != 1) begin n_fail++; $display("[TB] FAIL l0_err: got err=%b edges=%0d expected 1 1", er, ed); end
    sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] mem_hs_port directed bench");
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
